// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: converts level/edge peripheral lines into at most one
// outstanding PLIC request per source, with claim/complete handshake and edge counting.
module plic_gateway #(
   parameter int unsigned         NUM_SRC   = 3,
   parameter logic [NUM_SRC-1:0]  EDGE_MASK = '0,
   parameter int unsigned         CNT_W     = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_SRC-1:0] src_irq_i,
   input  logic               claim_valid_i,
   input  logic [3:0]         claim_id_i,
   input  logic               complete_valid_i,
   input  logic [3:0]         complete_id_i,
   output logic [NUM_SRC-1:0] pending_o,
   output logic [NUM_SRC-1:0] in_service_o,
   output logic [NUM_SRC-1:0] edge_ovf_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_SERV = 2'd2
   } state_t;

   state_t             r_state     [NUM_SRC];
   state_t             w_state_nxt [NUM_SRC];
   logic [CNT_W-1:0]   r_cnt       [NUM_SRC];
   logic [CNT_W-1:0]   w_cnt_nxt   [NUM_SRC];
   logic [NUM_SRC-1:0] r_src_q;
   logic [NUM_SRC-1:0] r_src_prev;
   logic [NUM_SRC-1:0] r_ovf;
   logic [NUM_SRC-1:0] w_ovf_nxt;
   logic [NUM_SRC-1:0] w_trig;
   logic [NUM_SRC-1:0] w_claim_hit;
   logic [NUM_SRC-1:0] w_comp_hit;

   // Edge sources need a rising edge; level sources just the sampled line.
   assign w_trig = r_src_q & ~(r_src_prev & EDGE_MASK);

   // ID decode; out-of-range and zero IDs never match any source.
   for (genvar g = 0; g < NUM_SRC; g++) begin : g_dec
      assign w_claim_hit[g]  = claim_valid_i    && (claim_id_i    == 4'(g + 1));
      assign w_comp_hit[g]   = complete_valid_i && (complete_id_i == 4'(g + 1));
      assign pending_o[g]    = (r_state[g] == ST_PEND);
      assign in_service_o[g] = (r_state[g] == ST_SERV);
   end

   assign edge_ovf_o = r_ovf;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_src_q    <= '0;
         r_src_prev <= '0;
         r_ovf      <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
         end
      end else begin
         r_src_q    <= src_irq_i;
         r_src_prev <= r_src_q;
         r_ovf      <= w_ovf_nxt;
         for (int i = 0; i < NUM_SRC; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
         end
      end
   end

   always_comb begin
      w_ovf_nxt = r_ovf;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
      end

      for (int i = 0; i < NUM_SRC; i++) begin
         case (r_state[i])
            ST_IDLE: if (w_trig[i]) w_state_nxt[i] = ST_PEND;
            ST_PEND: if (w_claim_hit[i]) w_state_nxt[i] = ST_SERV;
            ST_SERV: begin
               if (w_comp_hit[i]) begin
                  if (EDGE_MASK[i]) begin
                     // Effective count = stored count + this cycle's edge; consume one.
                     if ((r_cnt[i] != '0) || w_trig[i]) begin
                        w_state_nxt[i] = ST_PEND;
                        if (!w_trig[i]) w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
                     end else begin
                        w_state_nxt[i] = ST_IDLE;
                     end
                  end else begin
                     w_state_nxt[i] = r_src_q[i] ? ST_PEND : ST_IDLE;
                  end
               end
            end
            default: w_state_nxt[i] = ST_IDLE;
         endcase

         // Edges arriving while a request is outstanding are banked.
         if (EDGE_MASK[i] && w_trig[i] && (r_state[i] != ST_IDLE)) begin
            if (r_cnt[i] == CNT_MAX) begin
               w_ovf_nxt[i] = 1'b1;
            end else if (!((r_state[i] == ST_SERV) && w_comp_hit[i])) begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway: level source 1/3, edge source 2 with a 2-bit counter.
module tb_plic_gateway;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [2:0] src_irq_i;
   logic       claim_valid_i;
   logic [3:0] claim_id_i;
   logic       complete_valid_i;
   logic [3:0] complete_id_i;
   logic [2:0] pending_o;
   logic [2:0] in_service_o;
   logic [2:0] edge_ovf_o;

   int n_pass  = 0;
   int n_total = 0;

   plic_gateway #(
      .NUM_SRC   (3),
      .EDGE_MASK (3'b010),
      .CNT_W     (2)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .src_irq_i        (src_irq_i),
      .claim_valid_i    (claim_valid_i),
      .claim_id_i       (claim_id_i),
      .complete_valid_i (complete_valid_i),
      .complete_id_i    (complete_id_i),
      .pending_o        (pending_o),
      .in_service_o     (in_service_o),
      .edge_ovf_o       (edge_ovf_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0] src;
      logic       cv;
      logic [3:0] cid;
      logic       pv;
      logic [3:0] pid;
      logic [2:0] ep;
      logic [2:0] es;
   } vec_t;

   vec_t vecs [22];

   task automatic cyc(input logic [2:0] s, input logic cv, input logic [3:0] cid,
                      input logic pv, input logic [3:0] pid);
      src_irq_i        = s;
      claim_valid_i    = cv;
      claim_id_i       = cid;
      complete_valid_i = pv;
      complete_id_i    = pid;
      @(posedge clk_i);
      #1;
      claim_valid_i    = 1'b0;
      complete_valid_i = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [2:0] ep, input logic [2:0] es,
                      input logic [2:0] eo);
      n_total++;
      if (pending_o !== ep || in_service_o !== es || edge_ovf_o !== eo)
         $display("FAIL %s: got pend=%b serv=%b ovf=%b, want pend=%b serv=%b ovf=%b",
                  nm, pending_o, in_service_o, edge_ovf_o, ep, es, eo);
      else
         n_pass++;
   endtask

   task automatic pulse2();
      cyc(3'b010, 1'b0, 4'd0, 1'b0, 4'd0);
      cyc(3'b000, 1'b0, 4'd0, 1'b0, 4'd0);
   endtask

   // Drain a banked count of three: each complete re-requests, then the last goes idle.
   task automatic drain3(input string tag, input logic [2:0] eo);
      for (int k = 0; k < 3; k++) begin
         cyc(3'b000, 1'b0, 4'd0, 1'b1, 4'd2);
         chk($sformatf("%s_recomp%0d", tag, k), 3'b010, 3'b000, eo);
         cyc(3'b000, 1'b1, 4'd2, 1'b0, 4'd0);
         chk($sformatf("%s_reclaim%0d", tag, k), 3'b000, 3'b010, eo);
      end
      cyc(3'b000, 1'b0, 4'd0, 1'b1, 4'd2);
      chk({tag, "_final"}, 3'b000, 3'b000, eo);
   endtask

   initial begin
      // src, claim_v, claim_id, comp_v, comp_id, exp pending, exp in_service
      vecs[0]  = '{3'b001, 1'b0, 4'd0, 1'b0, 4'd0, 3'b000, 3'b000};
      vecs[1]  = '{3'b001, 1'b0, 4'd0, 1'b0, 4'd0, 3'b001, 3'b000};
      vecs[2]  = '{3'b001, 1'b1, 4'd1, 1'b0, 4'd0, 3'b000, 3'b001};
      vecs[3]  = '{3'b001, 1'b0, 4'd0, 1'b1, 4'd1, 3'b001, 3'b000};
      vecs[4]  = '{3'b000, 1'b1, 4'd1, 1'b0, 4'd0, 3'b000, 3'b001};
      vecs[5]  = '{3'b000, 1'b0, 4'd0, 1'b1, 4'd1, 3'b000, 3'b000};
      vecs[6]  = '{3'b000, 1'b0, 4'd0, 1'b0, 4'd0, 3'b000, 3'b000};
      vecs[7]  = '{3'b101, 1'b0, 4'd0, 1'b0, 4'd0, 3'b000, 3'b000};
      vecs[8]  = '{3'b101, 1'b0, 4'd0, 1'b0, 4'd0, 3'b101, 3'b000};
      vecs[9]  = '{3'b101, 1'b1, 4'd0, 1'b0, 4'd0, 3'b101, 3'b000};
      vecs[10] = '{3'b101, 1'b1, 4'd5, 1'b0, 4'd0, 3'b101, 3'b000};
      vecs[11] = '{3'b101, 1'b0, 4'd0, 1'b1, 4'd3, 3'b101, 3'b000};
      vecs[12] = '{3'b000, 1'b1, 4'd3, 1'b0, 4'd0, 3'b001, 3'b100};
      vecs[13] = '{3'b000, 1'b1, 4'd1, 1'b1, 4'd3, 3'b000, 3'b001};
      vecs[14] = '{3'b000, 1'b0, 4'd0, 1'b1, 4'd1, 3'b000, 3'b000};
      vecs[15] = '{3'b001, 1'b0, 4'd0, 1'b0, 4'd0, 3'b000, 3'b000};
      vecs[16] = '{3'b001, 1'b0, 4'd0, 1'b0, 4'd0, 3'b001, 3'b000};
      vecs[17] = '{3'b001, 1'b1, 4'd1, 1'b1, 4'd1, 3'b000, 3'b001};
      vecs[18] = '{3'b000, 1'b1, 4'd1, 1'b1, 4'd1, 3'b001, 3'b000};
      vecs[19] = '{3'b000, 1'b1, 4'd1, 1'b0, 4'd0, 3'b000, 3'b001};
      vecs[20] = '{3'b000, 1'b0, 4'd0, 1'b1, 4'd1, 3'b000, 3'b000};
      vecs[21] = '{3'b000, 1'b1, 4'd0, 1'b1, 4'd3, 3'b000, 3'b000};

      rst_i            = 1'b1;
      src_irq_i        = '0;
      claim_valid_i    = 1'b0;
      claim_id_i       = '0;
      complete_valid_i = 1'b0;
      complete_id_i    = '0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset", 3'b000, 3'b000, 3'b000);
      rst_i = 1'b0;

      // Level sources, illegal IDs, same-cycle claim/complete
      for (int v = 0; v < 22; v++) begin
         cyc(vecs[v].src, vecs[v].cv, vecs[v].cid, vecs[v].pv, vecs[v].pid);
         chk($sformatf("vec%0d", v), vecs[v].ep, vecs[v].es, 3'b000);
      end

      // Edge source 2: three banked edges during service
      pulse2();
      chk("edge_req", 3'b010, 3'b000, 3'b000);
      cyc(3'b000, 1'b1, 4'd2, 1'b0, 4'd0);
      chk("edge_claim", 3'b000, 3'b010, 3'b000);
      repeat (3) pulse2();
      chk("edge_banked", 3'b000, 3'b010, 3'b000);
      drain3("edge", 3'b000);

      // Saturation: fourth edge overflows the 2-bit counter
      pulse2();
      cyc(3'b000, 1'b1, 4'd2, 1'b0, 4'd0);
      chk("sat_claim", 3'b000, 3'b010, 3'b000);
      repeat (3) pulse2();
      chk("sat_three", 3'b000, 3'b010, 3'b000);
      pulse2();
      chk("sat_ovf", 3'b000, 3'b010, 3'b010);
      drain3("sat", 3'b010);

      // Reset mid-service with a banked count of two
      pulse2();
      cyc(3'b000, 1'b1, 4'd2, 1'b0, 4'd0);
      repeat (2) pulse2();
      chk("rst_pre", 3'b000, 3'b010, 3'b010);
      rst_i = 1'b1;
      cyc(3'b000, 1'b0, 4'd0, 1'b0, 4'd0);
      chk("rst_mid", 3'b000, 3'b000, 3'b000);
      rst_i = 1'b0;
      repeat (2) cyc(3'b000, 1'b0, 4'd0, 1'b0, 4'd0);
      chk("rst_quiet", 3'b000, 3'b000, 3'b000);
      cyc(3'b001, 1'b0, 4'd0, 1'b0, 4'd0);
      chk("rst_lat", 3'b000, 3'b000, 3'b000);
      cyc(3'b001, 1'b0, 4'd0, 1'b0, 4'd0);
      chk("rst_rereq", 3'b001, 3'b000, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
